dct_quant_zigzag: RTL and testbench

Quantizes the 4x4 coefficient block streamed out of the DCT stage and re-emits it in zigzag order for the downstream entropy coder. It sits directly after the DCT stage and uses the same serial protocol on its input: 16 consecutive valid beats of signed 10-bit coefficients in row-major order. Each coefficient is divided by a fixed power-of-two step and stored in a 16-entry buffer. The buffer is then drained as 16 consecutive output beats in zigzag order.

---
 rtl/dct_pkg.sv | 29 ++
 rtl/dct_quant_unit.sv | 43 ++++
 rtl/dct_quant_zigzag.sv | 126 ++++++++++++
 tb/tb_dct_quant_zigzag.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants, tables and FSM state type for the 4x4 quantize/zigzag block.
package dct_pkg;

    localparam int COEF_W = 10;
    localparam int BLK_N  = 16;

    // Quantization step exponent per row-major coefficient index.
    localparam logic [1:0] QSHIFT [0:BLK_N-1] = '{
        2'd0, 2'd1, 2'd1, 2'd2,
        2'd1, 2'd1, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd3,
        2'd2, 2'd2, 2'd3, 2'd3
    };

    // Row-major buffer index emitted at each output position.
    localparam logic [3:0] ZZ_ORDER [0:BLK_N-1] = '{
        4'd0,  4'd1,  4'd4,  4'd8,
        4'd5,  4'd2,  4'd3,  4'd6,
        4'd9,  4'd12, 4'd13, 4'd10,
        4'd7,  4'd11, 4'd14, 4'd15
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/dct_quant_unit.sv
// Combinational divide by 2^s.
// Default build truncates toward zero; with QZ_ROUND_EN defined it rounds
// half away from zero (s=0 always passes x through).
module dct_quant_unit
    import dct_pkg::*;
(
    input  logic signed [COEF_W-1:0] x,
    input  logic        [1:0]        s,
    output logic signed [COEF_W-1:0] q
);

    // One extra bit of headroom so |x| of the most negative input and the
    // bias additions never wrap.
    logic signed [COEF_W:0] xe;
    logic signed [COEF_W:0] res;
`ifdef QZ_ROUND_EN
    logic signed [COEF_W:0] mag;
    logic signed [COEF_W:0] shifted;
`else
    logic signed [COEF_W:0] bias;
`endif

    // Scale the coefficient by the step for its position.
    always_comb begin
        xe  = {x[COEF_W-1], x};
`ifdef QZ_ROUND_EN
        mag     = x[COEF_W-1] ? -xe : xe;
        shifted = '0;
        if (s == 2'd0) begin
            res = xe;
        end else begin
            shifted = (mag + (11'sd1 <<< (s - 2'd1))) >>> s;
            res     = x[COEF_W-1] ? -shifted : shifted;
        end
`else
        // Negative values get 2^s-1 added so the arithmetic shift rounds toward zero.
        bias = x[COEF_W-1] ? ((11'sd1 <<< s) - 11'sd1) : '0;
        res  = (xe + bias) >>> s;
`endif
        q = res[COEF_W-1:0];
    end

endmodule

// File: rtl/dct_quant_zigzag.sv
// Quantizes a 16-beat row-major 4x4 coefficient block and re-emits it in
// zigzag order. Optional macro QZ_ROUND_EN selects rounding inside
// dct_quant_unit; interface and timing are identical either way.
//
// Protocol: valid-only streaming, no backpressure. in_valid marks each
// input beat and must stay high for 16 consecutive cycles per block; a
// block starts only from IDLE. out_valid is high for 16 consecutive cycles
// per block, out_last marks the 16th, and out_data is 0 when out_valid is 0.
// Short blocks and beats arriving during the drain raise a one-cycle blk_err.
module dct_quant_zigzag
    import dct_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [COEF_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [COEF_W-1:0] out_data,
    output logic                     out_last,
    output logic                     blk_err,
    output state_e                   dbg_state
);

    state_e                   state, state_nxt;
    logic [3:0]               in_cnt, in_cnt_nxt;
    logic [3:0]               out_cnt, out_cnt_nxt;
    logic                     cap_en;
    logic                     out_valid_nxt, out_last_nxt, blk_err_nxt;
    logic signed [COEF_W-1:0] out_data_nxt;
    logic signed [COEF_W-1:0] q;
    logic signed [COEF_W-1:0] qbuf [0:BLK_N-1];

    // in_cnt is 0 in IDLE, so it also indexes the first beat of a new block.
    dct_quant_unit u_quant (
        .x (in_data),
        .s (QSHIFT[in_cnt]),
        .q (q)
    );

    assign dbg_state = state;

    // Next-state, counter and registered-output decisions.
    always_comb begin
        state_nxt     = state;
        in_cnt_nxt    = in_cnt;
        out_cnt_nxt   = out_cnt;
        cap_en        = 1'b0;
        out_valid_nxt = 1'b0;
        out_last_nxt  = 1'b0;
        out_data_nxt  = '0;
        blk_err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    cap_en     = 1'b1;
                    in_cnt_nxt = 4'd1;
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    cap_en = 1'b1;
                    if (in_cnt == 4'd15) begin
                        in_cnt_nxt  = 4'd0;
                        out_cnt_nxt = 4'd0;
                        state_nxt   = DRAIN;
                    end else begin
                        in_cnt_nxt = in_cnt + 4'd1;
                    end
                end else begin
                    // Short block: drop what was captured.
                    blk_err_nxt = 1'b1;
                    in_cnt_nxt  = 4'd0;
                    state_nxt   = IDLE;
                end
            end
            DRAIN: begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = qbuf[ZZ_ORDER[out_cnt]];
                out_last_nxt  = (out_cnt == 4'd15);
                // Any input beat here is an overlap and is dropped.
                blk_err_nxt   = in_valid;
                if (out_cnt == 4'd15) begin
                    out_cnt_nxt = 4'd0;
                    state_nxt   = IDLE;
                end else begin
                    out_cnt_nxt = out_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                in_cnt_nxt  = 4'd0;
                out_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_cnt    <= 4'd0;
            out_cnt   <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            blk_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_cnt    <= in_cnt_nxt;
            out_cnt   <= out_cnt_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_last  <= out_last_nxt;
            blk_err   <= blk_err_nxt;
        end
    end

    // Coefficient buffer holds quantized values; contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            qbuf[in_cnt] <= q;
        end
    end

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Bench for dct_quant_zigzag: random and directed blocks against a
// behavioural division/zigzag model, with literal pins on the model.
module tb_dct_quant_zigzag;
    import dct_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [9:0] in_data;
    logic       out_valid;
    logic [9:0] out_data;
    logic       out_last;
    logic       blk_err;
    state_e     dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_seen = 0;
    int exp_err = 0;

    logic [9:0] exp_q[$];
    logic       last_q[$];
    int         cyc_q[$];

    int tb_qshift[16] = '{0, 1, 1, 2, 1, 1, 2, 2, 1, 2, 2, 3, 2, 2, 3, 3};
    int tb_zz[16];
    int zz_lit[16]    = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
`ifdef QZ_ROUND_EN
    int lit100[16]    = '{100, 50, 50, 50, 50, 50, 25, 25, 25, 25, 25, 25, 25, 13, 13, 13};
`else
    int lit100[16]    = '{100, 50, 50, 50, 50, 50, 25, 25, 25, 25, 25, 25, 25, 12, 12, 12};
`endif

    dct_quant_zigzag dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .blk_err   (blk_err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    // Integer division by 2^s; SV '/' on ints truncates toward zero.
    function automatic int model_q(input int x, input int s);
        int d;
        d = 1 << s;
`ifdef QZ_ROUND_EN
        if (s == 0) return x;
        if (x < 0) return -((-x + d / 2) / d);
        return (x + d / 2) / d;
`else
        return x / d;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [9:0] d;
        logic       l;
        int         c;
        if (!rst) begin
            if (blk_err) err_seen++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    d = exp_q.pop_front();
                    l = last_q.pop_front();
                    c = cyc_q.pop_front();
                    check("out_data", int'(out_data), int'(d));
                    check("out_last", int'(out_last), int'(l));
                    check("out_cycle", cyc, c);
                end
            end else begin
                check("idle_data_zero", int'(out_data), 0);
                check("idle_last_zero", int'(out_last), 0);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_block(input int vals[16], input int nbeats);
        int base;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = (i < 16) ? 10'(vals[i]) : 10'($urandom_range(0, 1023));
            if (i == 15) begin
                // Beat 15 is sampled at the next edge (cycle base+1);
                // output j then appears after edge base+2+j.
                base = cyc;
                for (int j = 0; j < 16; j++) begin
                    exp_q.push_back(10'(model_q(vals[tb_zz[j]], tb_qshift[tb_zz[j]])));
                    last_q.push_back(j == 15);
                    cyc_q.push_back(base + 2 + j);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        if (nbeats != 16) exp_err++;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check({name, "_drain_timeout"}, exp_q.size(), 0);
            exp_q.delete();
            last_q.delete();
            cyc_q.delete();
        end
        repeat (3) @(negedge clk);
        #1;
        check({name, "_blk_err_count"}, err_seen, exp_err);
    endtask

    task automatic rand_vals(output int vals[16]);
        int v;
        for (int k = 0; k < 16; k++) begin
            v = int'($urandom_range(0, 1023));
            if (v > 511) v = v - 1024;
            vals[k] = v;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int vals[16];
        int idx;
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Model pins: zigzag walk, all-100 block, rounding cases, extremes.
        idx = 0;
        for (int d = 0; d < 7; d++) begin
            for (int t = 0; t < 4; t++) begin
                int r;
                int c;
                r = (d % 2 == 1) ? t : 3 - t;
                c = d - r;
                if (c >= 0 && c < 4) begin
                    tb_zz[idx] = 4 * r + c;
                    idx++;
                end
            end
        end
        for (int j = 0; j < 16; j++) check("pin_zigzag", tb_zz[j], zz_lit[j]);
        for (int j = 0; j < 16; j++) check("pin_all100", model_q(100, tb_qshift[tb_zz[j]]), lit100[j]);
`ifdef QZ_ROUND_EN
        check("pin_round_m3_k1", model_q(-3, tb_qshift[1]), -2);
`else
        check("pin_round_m3_k1", model_q(-3, tb_qshift[1]), -1);
`endif
        check("pin_round_m5_k3", model_q(-5, tb_qshift[3]), -1);
        check("pin_max_k0", model_q(511, tb_qshift[0]), 511);
        check("pin_min_k0", model_q(-512, tb_qshift[0]), -512);

        // Reset state.
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_blk_err", int'(blk_err), 0);
        check("rst_state", int'(dbg_state), int'(IDLE));
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // All-100 block.
        for (int k = 0; k < 16; k++) vals[k] = 100;
        send_block(vals, 16);
        wait_drain("all100");

        // Row-major ramp.
        for (int k = 0; k < 16; k++) vals[k] = k;
        send_block(vals, 16);
        wait_drain("ramp");

        // Rounding positions plus positive extreme at k=0.
        rand_vals(vals);
        vals[0] = 511; vals[1] = -3; vals[3] = -5;
        send_block(vals, 16);
        wait_drain("round_max");

        // Negative extreme at k=0, extremes scattered elsewhere.
        rand_vals(vals);
        vals[0] = -512; vals[5] = 511; vals[11] = -512; vals[15] = 511;
        send_block(vals, 16);
        wait_drain("round_min");

        // Short block then a full block.
        rand_vals(vals);
        send_block(vals, 9);
        repeat (20) @(negedge clk);
        rand_vals(vals);
        send_block(vals, 16);
        wait_drain("short");

        // 17-beat burst: extra beat dropped, normal drain.
        rand_vals(vals);
        send_block(vals, 17);
        wait_drain("burst17");

        // Reset during the drain.
        rand_vals(vals);
        send_block(vals, 16);
        n = 0;
        while (exp_q.size() > 11 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_mid_reached_drain", exp_q.size(), 11);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", int'(out_valid), 0);
        check("rst_mid_out_data", int'(out_data), 0);
        check("rst_mid_state", int'(dbg_state), int'(IDLE));
        exp_q.delete();
        last_q.delete();
        cyc_q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rand_vals(vals);
        send_block(vals, 16);
        wait_drain("after_rst");

        // Random blocks.
        for (int b = 0; b < 6; b++) begin
            rand_vals(vals);
            send_block(vals, 16);
            wait_drain("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
